// File: rtl/and_operand_fifo.sv
// Operand-pair FWFT FIFO feeding the 4-bit AND stage.
// Head pair is driven on a/b; a/b are forced to zero whenever the FIFO is empty.

module and_operand_fifo_chk #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W:0]   count,
   input  logic              in_ready,
   input  logic              out_valid,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
   a_valid_count: assert property (@(posedge clk) disable iff (rst) out_valid == (count != '0));
   a_ready_count: assert property (@(posedge clk) disable iff (rst) in_ready == (count != FULL_CNT));
   a_empty_zero:  assert property (@(posedge clk) disable iff (rst) !out_valid |-> (a == '0 && b == '0));
endmodule

module and_operand_fifo #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in1,
   input  logic [WIDTH-1:0]  in2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  a,
   output logic [WIDTH-1:0]  b,
   output logic [ADDR_W:0]   count
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem_a_q [DEPTH];
   logic [WIDTH-1:0]  mem_b_q [DEPTH];
   logic [WIDTH-1:0]  mem_a_d [DEPTH];
   logic [WIDTH-1:0]  mem_b_d [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              push_s;
   logic              pop_s;

   always_comb begin
      in_ready  = !rst && (count_q != FULL_CNT);
      out_valid = (count_q != '0);
      push_s    = in_valid && in_ready;
      pop_s     = out_valid && out_ready;
      count     = count_q;

      if (out_valid) begin
         a = mem_a_q[rd_ptr_q];
         b = mem_b_q[rd_ptr_q];
      end else begin
         a = '0;
         b = '0;
      end

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_a_d  = mem_a_q;
      mem_b_d  = mem_b_q;

      if (push_s) begin
         mem_a_d[wr_ptr_q] = in1;
         mem_b_d[wr_ptr_q] = in2;
         wr_ptr_d          = wr_ptr_q + ADDR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      // Occupancy is tracked explicitly; pointer equality alone cannot tell full from empty.
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left uncleared by reset; a/b masking hides stale entries.
   always_ff @(posedge clk) begin
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
   end

   and_operand_fifo_chk #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_chk (
      .clk       (clk),
      .rst       (rst),
      .count     (count_q),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .a         (a),
      .b         (b)
   );
endmodule
